// File: rtl/ti_pkg.sv
// Shared types for the SN76489 write-port driver: command record, writer FSM states
// and the byte-formatting helpers used to serialise commands.
package ti_pkg;

    localparam logic       LATCH_MARK = 1'b1;
    localparam logic [1:0] NOISE_CHAN = 2'd3;

    typedef struct packed {
        logic [1:0] chan;
        logic       vol;
        logic [9:0] value;
    } ti_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_WAIT
    } wr_state_t;

    function automatic logic is_tone(input ti_cmd_t c);
        return !c.vol && (c.chan != NOISE_CHAN);
    endfunction

    // Noise control only has three meaningful bits; bit 3 of the nibble stays 0.
    function automatic logic [7:0] latch_byte(input ti_cmd_t c);
        logic [3:0] v;
        v = (!c.vol && (c.chan == NOISE_CHAN)) ? {1'b0, c.value[2:0]} : c.value[3:0];
        return {LATCH_MARK, c.chan, c.vol, v};
    endfunction

    function automatic logic [7:0] data_byte(input ti_cmd_t c);
        return {2'b00, c.value[9:4]};
    endfunction

endpackage

// File: rtl/ti_cmd_fifo.sv
// Synchronous power-of-two FIFO of ti_cmd_t with full/empty/count status.
// Read data is the head entry, valid whenever empty is low (show-ahead).
module ti_cmd_fifo
    import ti_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   push,
    input  ti_cmd_t                wr_data,
    input  logic                   pop,
    output ti_cmd_t                rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    ti_cmd_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; count/pointers alone define validity, and a reset-free array maps to plain RAM.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ti_bus_writer.sv
// Serialises buffered register commands into SN76489 latch/data bytes, paced by READY.
// Optional READY watchdog enabled by defining TI_BUS_WRITER_TIMEOUT_EN.
module ti_bus_writer
    import ti_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int READY_TIMEOUT = 256
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_chan,
    input  logic       cmd_vol,
    input  logic [9:0] cmd_value,
    input  logic       READY,
    output logic [7:0] D,
    output logic       nWE,
    output logic       nCE,
    output logic       busy,
    output logic       err_timeout
);

    wr_state_t                    state;
    wr_state_t                    state_nxt;
    ti_cmd_t                      cmd_in;
    ti_cmd_t                      fifo_head;
    ti_cmd_t                      cmd_q;
    logic                         data_pend;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         pop;
    logic                         timeout_hit;

    assign cmd_in = '{chan: cmd_chan, vol: cmd_vol, value: cmd_value};

    ti_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .push    (cmd_valid),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef TI_BUS_WRITER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(READY_TIMEOUT) + 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    assign timeout_hit = (state == ST_WAIT) && !READY && (wait_cnt == WAIT_W'(READY_TIMEOUT - 1));
    assign err_timeout = err_q;

    // Counter is cleared in HOLD so it starts from zero on the first WAIT cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_HOLD)
                wait_cnt <= '0;
            else if (state == ST_WAIT && !READY)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    localparam int unused_ready_timeout = READY_TIMEOUT;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!fifo_empty) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = ST_HOLD;
            ST_HOLD:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (READY)
                    state_nxt = data_pend ? ST_SETUP : ST_IDLE;
                else if (timeout_hit)
                    state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset releases them at once.
    always_comb begin
        pop       = (state == ST_IDLE) && !fifo_empty;
        nWE       = (state != ST_STROBE);
        nCE       = (state != ST_STROBE);
        cmd_ready = !fifo_full;
        busy      = (fifo_count != '0) || (state != ST_IDLE);
    end

    // D is loaded only on the transitions into SETUP and otherwise holds.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            D         <= 8'h00;
            cmd_q     <= '0;
            data_pend <= 1'b0;
        end else if (pop) begin
            cmd_q     <= fifo_head;
            D         <= latch_byte(fifo_head);
            data_pend <= is_tone(fifo_head);
        end else if (state == ST_WAIT && READY && data_pend) begin
            D         <= data_byte(cmd_q);
            data_pend <= 1'b0;
        end else if (timeout_hit) begin
            data_pend <= 1'b0;
        end
    end

endmodule
